// File: rtl/adder_share_arbiter_if.sv
// Requester operand bus plus result bus of the shared adder.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_carry;
  logic [IDW-1:0]    res_id;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one W-bit adder among NREQ requesters; result registered one cycle after grant.
// A stalled result (res_valid && !res_ready) blocks all grants; ena=0 blocks grants but lets the result drain.
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  adder_share_arbiter_if.slave       bus
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic [IDW-1:0] id_q;

  logic           win_vld;
  logic [IDW-1:0] win_idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W:0]     add_d;
  logic           can_issue;
  logic           grant;

  // First valid requester at or after ptr_q, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_vld && bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = idx[IDW-1:0];
        a_sel   = bus.req_a[idx*W +: W];
        b_sel   = bus.req_b[idx*W +: W];
      end
    end
  end

  assign can_issue = ena && !rst && ((state_q == IDLE) || bus.res_ready);
  assign grant     = win_vld && can_issue;
  assign add_d     = {1'b0, a_sel} + {1'b0, b_sel};
  assign ptr_d     = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      // grant already implies the output slot is free or being consumed
      if (grant) begin
        state_q <= FULL;
        ptr_q   <= ptr_d;
        sum_q   <= add_d[W-1:0];
        carry_q <= add_d[W];
        id_q    <= win_idx;
      end else begin
        case (state_q)
          IDLE:    state_q <= IDLE;
          FULL:    if (bus.res_ready) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_carry = carry_q;
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed plus random bench for adder_share_arbiter against a cycle-level reference model.
module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;

  adder_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: result register contents and round-robin pointer.
  int m_vld   = 0;
  int m_sum   = 0;
  int m_carry = 0;
  int m_id    = 0;
  int m_ptr   = 0;

  int id_hist[$];
  int cnt[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int get_a(input int i);
    logic [NREQ*W-1:0] v;
    v = bus.req_a;
    return int'(v[i*W +: W]);
  endfunction

  function automatic int get_b(input int i);
    logic [NREQ*W-1:0] v;
    v = bus.req_b;
    return int'(v[i*W +: W]);
  endfunction

  // Winner the rules pick this cycle, or -1 when nothing may be granted.
  function automatic int model_win();
    int can;
    can = (ena && !rst && (!m_vld || bus.res_ready)) ? 1 : 0;
    if (!can) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = a[W-1:0];
    bus.req_b[i*W +: W] = b[W-1:0];
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    int win;
    int s;
    logic [NREQ-1:0] exp_rdy;
    #1;
    win = model_win();
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(bus.res_valid), m_vld);
    chk("res_sum",   32'(bus.res_sum),   m_sum);
    chk("res_carry", 32'(bus.res_carry), m_carry);
    chk("res_id",    32'(bus.res_id),    m_id);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ptr = 0;
    end else if (win >= 0) begin
      s       = get_a(win) + get_b(win);
      m_sum   = s % 256;
      m_carry = s / 256;
      m_id    = win;
      m_vld   = 1;
      m_ptr   = (win + 1) % NREQ;
    end else if (bus.res_ready) begin
      m_vld = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);

    // Reset for two cycles
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_sum",   32'(bus.res_sum),   0);
    chk("rst_id",    32'(bus.res_id),    0);

    // Single request on requester 2
    rst = 1'b0; ena = 1'b1; bus.res_ready = 1'b1;
    bus.req_valid = 4'b0100;
    set_req(2, 20, 22);
    #1 chk("t1_ready", 32'(bus.req_ready), 32'h4);
    cycle();
    chk("t1_valid", 32'(bus.res_valid), 1);
    chk("t1_sum",   32'(bus.res_sum),   42);
    chk("t1_carry", 32'(bus.res_carry), 0);
    chk("t1_id",    32'(bus.res_id),    2);
    bus.req_valid = '0;

    // Round-robin with all valid, starting from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 10 * i, i);
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("rr_valid", 32'(bus.res_valid), 1);
      id_hist.push_back(int'(bus.res_id));
    end
    foreach (cnt[i]) cnt[i] = 0;
    foreach (id_hist[k]) begin
      chk("rr_seq", 32'(id_hist[k]), k % NREQ);
      if (id_hist[k] >= 0 && id_hist[k] < NREQ) cnt[id_hist[k]]++;
    end
    foreach (cnt[i]) chk("rr_fair", 32'(cnt[i]), 2);

    // Overflow cases on requester 1
    bus.req_valid = 4'b0010;
    set_req(1, 8'hFF, 8'h01);
    cycle();
    chk("ovf1_sum",   32'(bus.res_sum),   0);
    chk("ovf1_carry", 32'(bus.res_carry), 1);
    chk("ovf1_id",    32'(bus.res_id),    1);
    set_req(1, 8'h80, 8'h80);
    cycle();
    chk("ovf2_sum",   32'(bus.res_sum),   0);
    chk("ovf2_carry", 32'(bus.res_carry), 1);

    // Backpressure: held result, no grants while stalled
    bus.req_valid = 4'b0011;
    set_req(0, 3, 4);
    bus.res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_ready", 32'(bus.req_ready), 0);
      cycle();
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_id",    32'(bus.res_id),    1);
      chk("bp_carry", 32'(bus.res_carry), 1);
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_next_ready", 32'(bus.req_ready), 32'h1);
    cycle();
    chk("bp_next_id",  32'(bus.res_id),  0);
    chk("bp_next_sum", 32'(bus.res_sum), 7);

    // Enable gating: drain, then hold off with ena=0
    bus.req_valid = '0;
    cycle();
    chk("drain_valid", 32'(bus.res_valid), 0);
    ena = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1 chk("ena_ready", 32'(bus.req_ready), 0);
      cycle();
      chk("ena_valid", 32'(bus.res_valid), 0);
    end
    ena = 1'b1;
    #1 chk("ena_resume", 32'(bus.req_ready), 32'h2);
    cycle();
    // ena=0 while FULL still lets the result drain
    ena = 1'b0;
    cycle();
    chk("ena_full_drain", 32'(bus.res_valid), 0);

    // Reset while stalled
    ena = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    cycle();
    chk("stall_valid", 32'(bus.res_valid), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstmid_valid", 32'(bus.res_valid), 0);
    chk("rstmid_sum",   32'(bus.res_sum),   0);
    chk("rstmid_id",    32'(bus.res_id),    0);
    bus.res_ready = 1'b1;
    #1 chk("rstmid_ready", 32'(bus.req_ready), 32'h1);
    cycle();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      ena           = ($urandom_range(0, 7) != 0);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 8'hFF : int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
